// File: rtl/pc_pkg.sv
// Shared types and default widths for the program counter controller.
package pc_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } pc_state_e;

    localparam int PC_WIDTH_DEF  = 4;
    localparam int CNT_WIDTH_DEF = 20;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV  = 4,
    parameter int CNT_WIDTH = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TICK_DIV - 1);

    logic [CNT_WIDTH-1:0] count;
    logic                 at_last;

    assign at_last = (count == LAST);

    // Gated with rst_n so a divide-by-one tick stays low while in reset.
    assign tick = at_last & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (at_last) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/program_counter_ctl.sv
// Program counter with run/halt/step control, jump load and breakpoint.
module program_counter_ctl
    import pc_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int TICK_DIV  = 4,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                halt,
    input  logic                step,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic                bp_en,
    input  logic [PC_WIDTH-1:0] bp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                cp,
    output logic                running,
    output logic                wrapped,
    output logic                bp_hit
);

    localparam logic [PC_WIDTH-1:0] ALL1 = '1;

    pc_state_e           state;
    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc = pc + PC_WIDTH'(1);

    tick_prescaler #(
        .TICK_DIV  (TICK_DIV),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (cp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STOPPED;
            pc      <= '0;
            running <= 1'b0;
            wrapped <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            bp_hit  <= 1'b0;
            // A jump is honoured in every state and suppresses the increment.
            if (load) begin
                pc <= load_addr;
            end
            unique case (state)
                STOPPED: begin
                    if (!halt && run) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end else if (!halt && step) begin
                        state   <= STEPPING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (halt) begin
                        state   <= STOPPED;
                        running <= 1'b0;
                    end else if (cp && !load) begin
                        pc      <= pc_inc;
                        wrapped <= (pc == ALL1);
                        if (bp_en && pc_inc == bp_addr) begin
                            bp_hit  <= 1'b1;
                            state   <= STOPPED;
                            running <= 1'b0;
                        end else if (!run) begin
                            state   <= STOPPED;
                            running <= 1'b0;
                        end
                    end else if (!run) begin
                        state   <= STOPPED;
                        running <= 1'b0;
                    end
                end
                STEPPING: begin
                    if (halt) begin
                        state   <= STOPPED;
                        running <= 1'b0;
                    end else if (cp) begin
                        if (!load) begin
                            pc      <= pc_inc;
                            wrapped <= (pc == ALL1);
                        end
                        state   <= STOPPED;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= STOPPED;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter_ctl.sv
// Randomised scoreboard bench for program_counter_ctl.
module tb_program_counter_ctl;

    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int M   = 1 << W;

    localparam int S_STOP = 0;
    localparam int S_RUN  = 1;
    localparam int S_STEP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run = 1'b0;
    logic         halt = 1'b0;
    logic         step = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_addr = '0;
    logic         bp_en = 1'b0;
    logic [W-1:0] bp_addr = '0;
    logic [W-1:0] pc;
    logic         cp;
    logic         running;
    logic         wrapped;
    logic         bp_hit;

    program_counter_ctl #(
        .PC_WIDTH  (W),
        .TICK_DIV  (DIV),
        .CNT_WIDTH (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .halt      (halt),
        .step      (step),
        .load      (load),
        .load_addr (load_addr),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cp        (cp),
        .running   (running),
        .wrapped   (wrapped),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int cp;
        int running;
        int wrapped;
        int bp_hit;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: mode, pc value, and edges since reset release
    int m_pc   = 0;
    int m_mode = S_STOP;
    int m_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: compare DUT state just after each edge with the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("pc", int'(pc), e.pc);
                check("cp", int'(cp), e.cp);
                check("running", int'(running), e.running);
                check("wrapped", int'(wrapped), e.wrapped);
                check("bp_hit", int'(bp_hit), e.bp_hit);
            end
        end
    end

    // Predict what the next clock edge produces from the inputs just driven
    task automatic model_step();
        exp_t e;
        bit   tick;
        bit   inc;
        int   npc;
        int   nmode;
        tick  = (m_cnt % DIV) == DIV - 1;
        inc   = 0;
        npc   = load ? int'(load_addr) : m_pc;
        nmode = m_mode;
        e.wrapped = 0;
        e.bp_hit  = 0;
        if (m_mode == S_STOP) begin
            if (!halt && run) nmode = S_RUN;
            else if (!halt && step) nmode = S_STEP;
        end else if (m_mode == S_RUN) begin
            if (halt) begin
                nmode = S_STOP;
            end else begin
                if (!run) nmode = S_STOP;
                if (tick && !load) begin
                    inc = 1;
                    if (bp_en && ((m_pc + 1) % M) == int'(bp_addr)) begin
                        e.bp_hit = 1;
                        nmode = S_STOP;
                    end
                end
            end
        end else begin
            if (halt) nmode = S_STOP;
            else if (tick) begin
                nmode = S_STOP;
                inc = !load;
            end
        end
        if (inc) begin
            npc = (m_pc + 1) % M;
            e.wrapped = (m_pc == M - 1);
        end
        m_pc   = npc;
        m_mode = nmode;
        m_cnt++;
        e.pc      = m_pc;
        e.cp      = ((m_cnt % DIV) == DIV - 1);
        e.running = (m_mode != S_STOP);
        q.push_back(e);
    endtask

    // Called at a falling edge: apply inputs, predict, wait one cycle
    task automatic drive(input bit r, input bit h, input bit s,
                         input bit l, input int la,
                         input bit be, input int ba);
        run       = r;
        halt      = h;
        step      = s;
        load      = l;
        load_addr = W'(la);
        bp_en     = be;
        bp_addr   = W'(ba);
        model_step();
        @(negedge clk);
    endtask

    // Asynchronous reset away from any edge; returns at a falling edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pc", int'(pc), 0);
        check("rst_cp", int'(cp), 0);
        check("rst_running", int'(running), 0);
        check("rst_wrapped", int'(wrapped), 0);
        check("rst_bp_hit", int'(bp_hit), 0);
        q.delete();
        m_pc   = 0;
        m_mode = S_STOP;
        m_cnt  = 0;
        run    = 1'b0;
        halt   = 1'b0;
        step   = 1'b0;
        load   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        @(negedge clk);
        do_reset();

        // Continuous run from reset
        repeat (12) drive(1, 0, 0, 0, 0, 0, 0);

        // Jump near the top and run through the wrap
        drive(1, 0, 0, 1, 14, 0, 0);
        repeat (16) drive(1, 0, 0, 0, 0, 0, 0);

        // Stop, park at 3, single step then idle over several ticks
        drive(0, 1, 0, 1, 3, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (14) drive(0, 0, 0, 0, 0, 0, 0);

        // Single step landing on the breakpoint address must not flag a hit
        drive(0, 0, 0, 1, 8, 1, 9);
        drive(0, 0, 1, 0, 0, 1, 9);
        repeat (8) drive(0, 0, 0, 0, 0, 1, 9);

        // Breakpoint stop while running, run held high
        drive(0, 0, 0, 1, 5, 1, 9);
        repeat (30) drive(1, 0, 0, 0, 0, 1, 9);

        // Jump on every cycle phase while running
        for (int i = 0; i < DIV; i++) begin
            repeat (i + 1) drive(1, 0, 0, 0, 0, 0, 0);
            drive(1, 0, 0, 1, 12, 0, 0);
        end
        drive(1, 0, 0, 1, 15, 0, 0);
        repeat (6) drive(1, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a run at pc 7
        guard = 0;
        while (m_pc != 7 && guard < 200) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            guard++;
        end
        check("reach_pc7", m_pc, 7);
        do_reset();
        repeat (10) drive(1, 0, 0, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, M - 1)),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, M - 1)));
            if (i == 1500) do_reset();
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
